fifo_write_arbiter: RTL

Round-robin write arbiter that shares one SRAM-backed FIFO write port among NUM_REQ independent producers. Each producer uses a valid/ready handshake. The arbiter grants the port to one producer at a time, for a burst of up to BURST_LEN beats. It drives the FIFO's w_en and write data, honours the FIFO's full flag as backpressure, and sits directly in front of the FIFO write side.

---
 rtl/fifo_write_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Define FIFO_WRITE_ARB_FIXED_PRIO_EN to select fixed lowest-index priority instead.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    last_id_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic [ID_W-1:0]       win_id;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  beat;

`ifdef FIFO_WRITE_ARB_FIXED_PRIO_EN
    always_comb begin
        win_id = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) win_id = ID_W'(i);
        end
    end
`else
    logic [ID_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester after last_id wins.
    always_comb begin
        win_id = '0;
        cand   = '0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            cand = ID_W'((int'(last_id_q) + i) % int'(NUM_REQ));
            if (req_valid[cand]) win_id = cand;
        end
    end
`endif

    always_comb begin
        owner_valid = req_valid[grant_id_q];
        owner_data  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        busy        = (state_q == StGrant);
        beat        = busy && owner_valid && !fifo_full;
        fifo_w_en   = beat;
        req_ready   = (busy && !fifo_full) ? grant_q : '0;
        fifo_w_data = busy ? owner_data : '0;
        grant       = grant_q;
        grant_id    = grant_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        state_q    <= StGrant;
                        grant_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                        grant_id_q <= win_id;
                        last_id_q  <= win_id;
                        beat_cnt_q <= '0;
                    end
                end
                StGrant: begin
                    if (!owner_valid) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                            state_q <= StIdle;
                            grant_q <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
